id_ex_pipe_stage: RTL and testbench
===================================

# id_ex_pipe_stage

Parametrised ID→EX pipeline stage that carries the decoded opcode, destination, immediate, operand values and write-enable controls from decode to execute. It adds a valid/ready handshake, a two-entry skid buffer, and a flush input for squashing wrong-path instructions. Stalls from EX propagate back to ID without a combinational path from `out_ready` to `in_ready` when `SKID=1`.

## Interface
- `OP_W`, 3, opcode width
- `DEST_W`, 5, destination field width
- `DATA_W`, 8, width of imm, reg_val, acc_val
- `SKID`, 1, 1 = two-entry skid buffer with registered `in_ready`; 0 = single register, `in_ready = !out_valid || out_ready`
- `clk` in 1: single clock, all state on rising edge
- `rst` in 1: synchronous, active-high reset
- `flush` in 1: squash all held and incoming entries
- `in_valid` in 1: upstream entry valid
- `in_ready` out 1: stage can accept
- `in_opcode` in OP_W; `in_dest` in DEST_W; `in_imm`, `in_reg_val`, `in_acc_val` in DATA_W each
- `in_reg_write`, `in_mem_write` in 1 each
- `out_valid` out 1: EX-side entry valid
- `out_ready` in 1: EX accepts entry
- `out_opcode`, `out_dest`, `out_imm`, `out_reg_val`, `out_acc_val`, `out_reg_write`, `out_mem_write` out: registered copies, widths match inputs

## Operation
- `acc = in_valid & in_ready`; `drn = out_valid & out_ready`.
- Storage:
  - main register M drives `out_*`.
  - skid register S exists only when `SKID=1`.
- States, with `SKID=1`:
  - EMPTY (`M` invalid)
  - ONE (`M` valid, `S` invalid)
  - TWO (both valid)
- Transitions:
  - EMPTY: `acc` → ONE, `M` ← input.
  - ONE: `acc & drn` → ONE, `M` ← input. `acc & !drn` → TWO, `S` ← input. `!acc & drn` → EMPTY.
  - TWO: `in_ready=0`, so no accept. `drn` → ONE, `M` ← `S`. Otherwise hold.
- `in_ready = !S_valid`, a pure register output.
- `SKID=0`: states EMPTY and ONE only. `in_ready` is combinational, as defined under Interface.
- Ordering is strict FIFO. No entry is duplicated or dropped except by flush.
- `out_valid=1` while in ONE or TWO.
- `out_*` are stable while `out_valid & !out_ready`.
- Flush:
  - Priority: `rst` > `flush` > normal operation.
  - Next state is EMPTY, `S` invalid.
  - All `out_*` are cleared to 0 and `out_valid` to 0.
  - `in_ready` is not gated by `flush`. A handshake in the flush cycle completes upstream and the entry is discarded.
  - A `drn` in the flush cycle still counts as consumed by EX.
- Reset, as the result of a `rst`-sampled edge:
  - `out_valid=0`
  - all `out_*` = 0
  - `S` invalid, so `in_ready=1`
  - `rst` asserted mid-stream discards all held entries.
- Control bits: `out_reg_write` and `out_mem_write` are 0 whenever `out_valid=0`. Data fields are don't-care then, but are 0 after reset or flush.
- No arithmetic. Every field is passed bit-exact.

## Timing
- Latency: an entry accepted at edge N is on `out_*` with `out_valid=1` after edge N. That is one cycle, from EMPTY or ONE with a simultaneous drain.
- Throughput: 1 entry/cycle while `out_ready=1`.
- `out_ready` falling with `in_valid` held:
  - `SKID=1`: one more entry is absorbed into `S`. `in_ready` drops the cycle after.
  - `SKID=0`: `in_ready` drops in the same cycle.
- Recovery: `out_ready` rising in TWO drains `M`, loads `S` into `M`, and raises `in_ready` at the next edge.
- Flush: `out_valid` is 0 the cycle after `flush` is sampled. An entry accepted the cycle after flush deasserts appears one cycle later, as normal.
- All outputs are registered except `in_ready` when `SKID=0`.

## Test plan
- **Reset:** drive inputs nonzero with `in_valid=1` during `rst=1` for 2 cycles → `out_valid=0`, all `out_*`=0, `in_ready=1` after the first reset edge.
- **Streaming:** `SKID=1`, `out_ready=1`, 8 back-to-back entries with opcodes 0..7 and imm `8'hA0+i` → outputs appear one cycle later in order, no gaps, `in_ready` constantly 1.
- **Backpressure:** `out_ready=0` for 3 cycles while feeding A, B, C → A is held on the output, B sits in `S`, `in_ready=0` from the cycle after B is accepted, and C waits. Release `out_ready` → A, B, C are delivered in order.
- **Flush in TWO:** flush with `in_valid=1` carrying D → next cycle `out_valid=0`, `out_reg_write=out_mem_write=0`, and D never appears. Send E afterwards → E is output one cycle later.
- **SKID=0:** same stimulus as the backpressure case → `in_ready` falls in the same cycle as `out_ready`, only A is held, and order is preserved.
- **Reset mid-stream:** reset in state TWO → all entries are lost, and outputs read 0 with `out_valid=0` next cycle.

Source files
------------

// File: rtl/id_ex_pipe_stage_if.sv
// Decode-to-execute bundle: upstream entry with handshake and the downstream copy with its handshake.
// "master" is the side around the stage (decode + execute); "slave" is the pipeline stage itself.
interface id_ex_pipe_stage_if #(
    parameter int OP_W   = 3,
    parameter int DEST_W = 5,
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [OP_W-1:0]   in_opcode;
    logic [DEST_W-1:0] in_dest;
    logic [DATA_W-1:0] in_imm;
    logic [DATA_W-1:0] in_reg_val;
    logic [DATA_W-1:0] in_acc_val;
    logic              in_reg_write;
    logic              in_mem_write;

    logic              out_valid;
    logic              out_ready;
    logic [OP_W-1:0]   out_opcode;
    logic [DEST_W-1:0] out_dest;
    logic [DATA_W-1:0] out_imm;
    logic [DATA_W-1:0] out_reg_val;
    logic [DATA_W-1:0] out_acc_val;
    logic              out_reg_write;
    logic              out_mem_write;

    modport master (
        output in_valid, in_opcode, in_dest, in_imm, in_reg_val, in_acc_val,
               in_reg_write, in_mem_write, out_ready,
        input  in_ready, out_valid, out_opcode, out_dest, out_imm, out_reg_val,
               out_acc_val, out_reg_write, out_mem_write
    );

    modport slave (
        input  in_valid, in_opcode, in_dest, in_imm, in_reg_val, in_acc_val,
               in_reg_write, in_mem_write, out_ready,
        output in_ready, out_valid, out_opcode, out_dest, out_imm, out_reg_val,
               out_acc_val, out_reg_write, out_mem_write
    );
endinterface

// File: rtl/id_ex_pipe_stage.sv
// ID->EX pipeline register with valid/ready handshake, optional two-entry skid buffer and flush.
// With SKID=1 in_ready is decoded from state only, breaking the out_ready->in_ready path.
module id_ex_pipe_stage #(
    parameter int OP_W   = 3,
    parameter int DEST_W = 5,
    parameter int DATA_W = 8,
    parameter int SKID   = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    id_ex_pipe_stage_if.slave   bus
);
    localparam int PW = OP_W + DEST_W + 3 * DATA_W + 2;

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] TWO   = 2'd2;

    logic [1:0]    state_reg;
    logic [1:0]    state_next;
    logic [PW-1:0] m_data_reg;
    logic [PW-1:0] m_data_next;
    logic [PW-1:0] s_data_reg;
    logic [PW-1:0] s_data_next;
    logic [PW-1:0] in_payload;

    logic m_valid;
    logic s_valid;
    logic in_ready_int;
    logic acc;
    logic drn;
    logic m_reg_write;
    logic m_mem_write;

    assign m_valid = (state_reg != EMPTY);
    assign s_valid = (state_reg == TWO);

    generate
        if (SKID != 0) begin : g_skid_ready
            assign in_ready_int = !s_valid;
        end else begin : g_single_ready
            assign in_ready_int = !m_valid || bus.out_ready;
        end
    endgenerate

    assign acc = bus.in_valid && in_ready_int;
    assign drn = m_valid && bus.out_ready;

    assign in_payload = {bus.in_opcode, bus.in_dest, bus.in_imm, bus.in_reg_val,
                         bus.in_acc_val, bus.in_reg_write, bus.in_mem_write};

    // Flush wins over any accept/drain; an entry handshaken in the flush cycle is dropped.
    always_comb begin
        state_next  = state_reg;
        m_data_next = m_data_reg;
        s_data_next = s_data_reg;
        if (flush) begin
            state_next  = EMPTY;
            m_data_next = '0;
            s_data_next = '0;
        end else begin
            case (state_reg)
                EMPTY: begin
                    if (acc) begin
                        state_next  = ONE;
                        m_data_next = in_payload;
                    end
                end
                ONE: begin
                    if (acc && drn) begin
                        m_data_next = in_payload;
                    end else if (acc) begin
                        if (SKID != 0) begin
                            state_next  = TWO;
                            s_data_next = in_payload;
                        end
                    end else if (drn) begin
                        state_next = EMPTY;
                    end
                end
                TWO: begin
                    if (drn) begin
                        state_next  = ONE;
                        m_data_next = s_data_reg;
                        s_data_next = '0;
                    end
                end
                default: begin
                    state_next  = EMPTY;
                    m_data_next = '0;
                    s_data_next = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= EMPTY;
            m_data_reg <= '0;
            s_data_reg <= '0;
        end else begin
            state_reg  <= state_next;
            m_data_reg <= m_data_next;
            s_data_reg <= s_data_next;
        end
    end

    assign bus.in_ready  = in_ready_int;
    assign bus.out_valid = m_valid;

    assign {bus.out_opcode, bus.out_dest, bus.out_imm, bus.out_reg_val,
            bus.out_acc_val, m_reg_write, m_mem_write} = m_data_reg;

    // Data is left stale after a plain drain, so the write enables are masked by valid.
    assign bus.out_reg_write = m_valid && m_reg_write;
    assign bus.out_mem_write = m_valid && m_mem_write;
endmodule

// File: tb/tb_id_ex_pipe_stage.sv
// Bench for id_ex_pipe_stage: SKID=1 and SKID=0 instances, scenario tasks plus an ordering scoreboard.
// Expected entries are queued on each upstream handshake and checked on each downstream drain.
module tb_id_ex_pipe_stage;
    localparam int OP_W   = 3;
    localparam int DEST_W = 5;
    localparam int DATA_W = 8;
    localparam int PW     = OP_W + DEST_W + 3 * DATA_W + 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          out_ready;
    logic [PW-1:0] in_pl;
    int            sel;

    int total = 0;
    int bad   = 0;
    int ndrain = 0;
    logic last_acc;
    logic [PW-1:0] sb[$];

    always #5 clk = ~clk;

    id_ex_pipe_stage_if #(.OP_W(OP_W), .DEST_W(DEST_W), .DATA_W(DATA_W)) bus0 ();
    id_ex_pipe_stage_if #(.OP_W(OP_W), .DEST_W(DEST_W), .DATA_W(DATA_W)) bus1 ();

    id_ex_pipe_stage #(.OP_W(OP_W), .DEST_W(DEST_W), .DATA_W(DATA_W), .SKID(1)) dut_skid (
        .clk(clk), .rst(rst), .flush(flush), .bus(bus0.slave)
    );
    id_ex_pipe_stage #(.OP_W(OP_W), .DEST_W(DEST_W), .DATA_W(DATA_W), .SKID(0)) dut_single (
        .clk(clk), .rst(rst), .flush(flush), .bus(bus1.slave)
    );

    assign bus0.in_valid  = in_valid && (sel == 0);
    assign bus1.in_valid  = in_valid && (sel == 1);
    assign bus0.out_ready = out_ready;
    assign bus1.out_ready = out_ready;
    assign {bus0.in_opcode, bus0.in_dest, bus0.in_imm, bus0.in_reg_val,
            bus0.in_acc_val, bus0.in_reg_write, bus0.in_mem_write} = in_pl;
    assign {bus1.in_opcode, bus1.in_dest, bus1.in_imm, bus1.in_reg_val,
            bus1.in_acc_val, bus1.in_reg_write, bus1.in_mem_write} = in_pl;

    logic          cur_in_ready;
    logic          cur_out_valid;
    logic [PW-1:0] cur_out;
    assign cur_in_ready  = (sel == 1) ? bus1.in_ready : bus0.in_ready;
    assign cur_out_valid = (sel == 1) ? bus1.out_valid : bus0.out_valid;
    assign cur_out = (sel == 1)
        ? {bus1.out_opcode, bus1.out_dest, bus1.out_imm, bus1.out_reg_val,
           bus1.out_acc_val, bus1.out_reg_write, bus1.out_mem_write}
        : {bus0.out_opcode, bus0.out_dest, bus0.out_imm, bus0.out_reg_val,
           bus0.out_acc_val, bus0.out_reg_write, bus0.out_mem_write};

    function automatic logic [PW-1:0] mk(input logic [OP_W-1:0] op, input logic [DEST_W-1:0] d,
                                         input logic [7:0] imm, input logic [7:0] rv,
                                         input logic [7:0] av, input logic rw, input logic mw);
        return {op, d, imm, rv, av, rw, mw};
    endfunction

    // One clock: sample handshakes at the falling edge, then update the scoreboard after the rise.
    task automatic cycle();
        logic s_acc, s_drn, s_fl, s_rst;
        logic [PW-1:0] s_out, s_in, e;
        @(negedge clk);
        s_acc = (in_valid === 1'b1) && (cur_in_ready === 1'b1);
        s_drn = (cur_out_valid === 1'b1) && (out_ready === 1'b1);
        s_fl  = flush;
        s_rst = rst;
        s_out = cur_out;
        s_in  = in_pl;
        @(posedge clk);
        #1;
        last_acc = s_acc && !s_rst && !s_fl;
        if (s_rst) begin
            sb.delete();
        end else begin
            if (s_drn) begin
                ndrain++;
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL sb_unexpected got=%h exp=none", s_out);
                end else begin
                    e = sb.pop_front();
                    if (s_out !== e) begin
                        bad++;
                        $display("FAIL sb_order got=%h exp=%h", s_out, e);
                    end else begin
                        $display("drain dut=%0d data=%h", sel, s_out);
                    end
                end
            end
            if (s_fl) sb.delete();
            else if (s_acc) sb.push_back(s_in);
        end
    endtask

    task automatic test_reset();
        in_valid = 1'b1;
        out_ready = 1'b1;
        in_pl = mk(3'h7, 5'h1f, 8'hff, 8'h5a, 8'ha5, 1'b1, 1'b1);
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            cycle();
            total++;
            if (cur_out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", cur_out_valid); end
            total++;
            if (cur_out !== '0) begin bad++; $display("FAIL reset_data got=%h exp=0", cur_out); end
            total++;
            if (cur_in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", cur_in_ready); end
            total++;
            if (bus1.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid_single got=%b exp=0", bus1.out_valid); end
        end
        rst = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic test_streaming();
        logic [7:0] iv;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            iv = 8'(i);
            in_pl = mk(iv[2:0], 5'(i + 1), 8'ha0 + iv, iv * 8'd3, ~iv, iv[0], iv[1]);
            in_valid = 1'b1;
            total++;
            if (cur_in_ready !== 1'b1) begin bad++; $display("FAIL stream_in_ready i=%0d got=%b exp=1", i, cur_in_ready); end
            cycle();
            total++;
            if (cur_out_valid !== 1'b1 || cur_out !== in_pl) begin
                bad++;
                $display("FAIL stream_out i=%0d got=%b/%h exp=1/%h", i, cur_out_valid, cur_out, in_pl);
            end
        end
        in_valid = 1'b0;
        cycle();
        total++;
        if (cur_out_valid !== 1'b0 || cur_out[1:0] !== 2'b00) begin
            bad++;
            $display("FAIL stream_idle got=%b/%b exp=0/00", cur_out_valid, cur_out[1:0]);
        end
    endtask

    task automatic test_backpressure();
        logic [PW-1:0] a, b, c;
        a = mk(3'd1, 5'd2, 8'h11, 8'h12, 8'h13, 1'b1, 1'b0);
        b = mk(3'd2, 5'd3, 8'h21, 8'h22, 8'h23, 1'b0, 1'b1);
        c = mk(3'd3, 5'd4, 8'h31, 8'h32, 8'h33, 1'b1, 1'b1);
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_pl = a;
        cycle();
        total++;
        if (cur_out !== a || cur_in_ready !== 1'b1) begin bad++; $display("FAIL bp_a got=%h/%b exp=%h/1", cur_out, cur_in_ready, a); end
        in_pl = b;
        cycle();
        total++;
        if (cur_out !== a || cur_in_ready !== 1'b0) begin bad++; $display("FAIL bp_b_skid got=%h/%b exp=%h/0", cur_out, cur_in_ready, a); end
        in_pl = c;
        cycle();
        total++;
        if (cur_out !== a || cur_in_ready !== 1'b0) begin bad++; $display("FAIL bp_c_wait got=%h/%b exp=%h/0", cur_out, cur_in_ready, a); end
        out_ready = 1'b1;
        cycle();
        total++;
        if (cur_out !== b || cur_in_ready !== 1'b1) begin bad++; $display("FAIL bp_rel_b got=%h/%b exp=%h/1", cur_out, cur_in_ready, b); end
        cycle();
        total++;
        if (cur_out !== c || cur_out_valid !== 1'b1) begin bad++; $display("FAIL bp_rel_c got=%h/%b exp=%h/1", cur_out, cur_out_valid, c); end
        in_valid = 1'b0;
        cycle();
        total++;
        if (cur_out_valid !== 1'b0) begin bad++; $display("FAIL bp_empty got=%b exp=0", cur_out_valid); end
    endtask

    task automatic test_flush();
        logic [PW-1:0] a, b, d, e;
        a = mk(3'd4, 5'd9, 8'h41, 8'h42, 8'h43, 1'b1, 1'b0);
        b = mk(3'd5, 5'd10, 8'h51, 8'h52, 8'h53, 1'b1, 1'b1);
        d = mk(3'd6, 5'd11, 8'hd1, 8'hd2, 8'hd3, 1'b1, 1'b1);
        e = mk(3'd7, 5'd12, 8'he1, 8'he2, 8'he3, 1'b0, 1'b1);
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_pl = a;
        cycle();
        in_pl = b;
        cycle();
        total++;
        if (cur_in_ready !== 1'b0) begin bad++; $display("FAIL flush_two got=%b exp=0", cur_in_ready); end
        in_pl = d;
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        total++;
        if (cur_out_valid !== 1'b0 || cur_out !== '0 || cur_in_ready !== 1'b1) begin
            bad++;
            $display("FAIL flush_clear got=%b/%h/%b exp=0/0/1", cur_out_valid, cur_out, cur_in_ready);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        cycle();
        total++;
        if (cur_out_valid !== 1'b0) begin bad++; $display("FAIL flush_no_d got=%b exp=0", cur_out_valid); end
        // Entry handshaken in the flush cycle from EMPTY must vanish.
        in_valid = 1'b1;
        in_pl = d;
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        total++;
        if (cur_out_valid !== 1'b0) begin bad++; $display("FAIL flush_drop_acc got=%b exp=0", cur_out_valid); end
        in_pl = e;
        cycle();
        total++;
        if (cur_out_valid !== 1'b1 || cur_out !== e) begin bad++; $display("FAIL flush_e got=%b/%h exp=1/%h", cur_out_valid, cur_out, e); end
        in_valid = 1'b0;
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        total++;
        if (cur_out_valid !== 1'b0 || cur_out[1:0] !== 2'b00) begin bad++; $display("FAIL flush_drain got=%b/%b exp=0/00", cur_out_valid, cur_out[1:0]); end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_pl = mk(3'd1, 5'd21, 8'h61, 8'h62, 8'h63, 1'b1, 1'b1);
        cycle();
        in_pl = mk(3'd2, 5'd22, 8'h71, 8'h72, 8'h73, 1'b1, 1'b0);
        cycle();
        total++;
        if (cur_in_ready !== 1'b0) begin bad++; $display("FAIL rstmid_two got=%b exp=0", cur_in_ready); end
        in_pl = mk(3'd3, 5'd23, 8'h81, 8'h82, 8'h83, 1'b0, 1'b1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        total++;
        if (cur_out_valid !== 1'b0 || cur_out !== '0 || cur_in_ready !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_clear got=%b/%h/%b exp=0/0/1", cur_out_valid, cur_out, cur_in_ready);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        cycle();
        total++;
        if (cur_out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_lost got=%b exp=0", cur_out_valid); end
    endtask

    task automatic test_skid0();
        logic [PW-1:0] a, b, c;
        a = mk(3'd1, 5'd2, 8'h11, 8'h12, 8'h13, 1'b1, 1'b0);
        b = mk(3'd2, 5'd3, 8'h21, 8'h22, 8'h23, 1'b0, 1'b1);
        c = mk(3'd3, 5'd4, 8'h31, 8'h32, 8'h33, 1'b1, 1'b1);
        sel = 1;
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_pl = a;
        cycle();
        total++;
        if (cur_out !== a || cur_in_ready !== 1'b1) begin bad++; $display("FAIL s0_a got=%h/%b exp=%h/1", cur_out, cur_in_ready, a); end
        out_ready = 1'b0;
        in_pl = b;
        #1;
        total++;
        if (cur_in_ready !== 1'b0) begin bad++; $display("FAIL s0_same_cycle got=%b exp=0", cur_in_ready); end
        for (int k = 0; k < 2; k++) begin
            cycle();
            total++;
            if (cur_out !== a || cur_in_ready !== 1'b0) begin bad++; $display("FAIL s0_hold k=%0d got=%h/%b exp=%h/0", k, cur_out, cur_in_ready, a); end
        end
        out_ready = 1'b1;
        #1;
        total++;
        if (cur_in_ready !== 1'b1) begin bad++; $display("FAIL s0_release got=%b exp=1", cur_in_ready); end
        cycle();
        total++;
        if (cur_out !== b) begin bad++; $display("FAIL s0_b got=%h exp=%h", cur_out, b); end
        in_pl = c;
        cycle();
        total++;
        if (cur_out !== c) begin bad++; $display("FAIL s0_c got=%h exp=%h", cur_out, c); end
        in_valid = 1'b0;
        cycle();
        total++;
        if (cur_out_valid !== 1'b0) begin bad++; $display("FAIL s0_empty got=%b exp=0", cur_out_valid); end
    endtask

    task automatic test_back_to_back(input int s);
        int n, sent, start;
        logic [63:0] r;
        sel = s;
        n = 40;
        sent = 0;
        start = ndrain;
        for (int cyc = 0; cyc < 600 && sent < n; cyc++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid = ($urandom_range(0, 2) != 0);
            r = {$urandom(), $urandom()};
            in_pl = r[PW-1:0];
            cycle();
            if (last_acc) sent++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 10 && sb.size() != 0; k++) cycle();
        total++;
        if (sent != n) begin bad++; $display("FAIL b2b_sent dut=%0d got=%0d exp=%0d", s, sent, n); end
        total++;
        if (ndrain - start != n) begin bad++; $display("FAIL b2b_drained dut=%0d got=%0d exp=%0d", s, ndrain - start, n); end
        total++;
        if (sb.size() != 0) begin bad++; $display("FAIL b2b_left dut=%0d got=%0d exp=0", s, sb.size()); end
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        in_pl = '0;
        sel = 0;
        last_acc = 1'b0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_reset_midstream();
        test_skid0();
        test_back_to_back(0);
        test_back_to_back(1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
